// File: rtl/bp_bram_write_arbiter_pkg.sv
// Shared constants and types for the BRAM write arbiter.
//   DataW / AddrW  : BRAM word and address widths.
//   FrameBeats     : port A words per complete decompressed polyvec.
//   ACntW          : width of the port A beat counter.
//   owner_e        : arbiter FSM state, also exported on the owner output.
package bp_bram_write_arbiter_pkg;

  localparam int unsigned DataW      = 96;
  localparam int unsigned AddrW      = 6;
  localparam int unsigned FrameBeats = 64;
  localparam int unsigned ACntW      = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } owner_e;

endpackage

// File: rtl/bp_bram_write_arbiter.sv
// Two-port write arbiter in front of a single BRAM write port.
//   Port A (ciphertext decompressor) always wins and cannot be stalled.
//   Port B (polynomial engine) is a valid/grant burst port that is stalled
//   while A is active and resumes afterwards with no lost or repeated beat.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   a_session_i, a_we_i     : port A session level and write strobe
//   a_wad_i, a_wdata_i      : port A write address / data
//   b_req_i, b_last_i       : port B write valid and last-beat marker
//   b_wad_i, b_wdata_i      : port B write address / data
//   b_gnt_o                 : port B beat accepted when b_req_i & b_gnt_o
//   bram_we_o/wad_o/wdata_o : registered BRAM write port (latency 1)
//   a_frame_done_o          : pulse with the write of the last beat of an A frame
//   b_burst_done_o          : pulse with the write of the B last beat
//   owner_o                 : FSM state (0 idle, 1 port A, 2 port B)
module bp_bram_write_arbiter
  import bp_bram_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W      = DataW,
  parameter int unsigned ADDR_W      = AddrW,
  parameter int unsigned FRAME_BEATS = FrameBeats
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_session_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_wad_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_req_i,
  input  logic [ADDR_W-1:0] b_wad_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic              b_last_i,
  output logic              b_gnt_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_wad_o,
  output logic [DATA_W-1:0] bram_wdata_o,
  output logic              a_frame_done_o,
  output logic              b_burst_done_o,
  output logic [1:0]        owner_o
);

  localparam logic [ACntW-1:0] ALastCnt = ACntW'(FRAME_BEATS - 1);

  owner_e              owner_q, owner_d;
  logic [ACntW-1:0]    a_cnt_q, a_cnt_d;
  logic                a_session_q;
  logic                bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_wad_q, bram_wad_d;
  logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
  logic                frame_done_q, frame_done_d;
  logic                burst_done_q;

  logic a_busy;
  logic b_acc;
  logic b_done;
  logic a_abort;

  assign a_busy  = a_session_i | a_we_i;
  // Gated by rst_n so B never sees a grant while the arbiter is held in reset.
  assign b_gnt_o = rst_n & (owner_q != StOwnA) & ~a_busy;
  assign b_acc   = b_req_i & b_gnt_o;
  assign b_done  = b_acc & b_last_i;
  // Session dropped before the frame completed: discard the partial count.
  assign a_abort = a_session_q & ~a_session_i & (a_cnt_q != '0);

  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      StIdle: begin
        if (a_busy) begin
          owner_d = StOwnA;
        end else if (b_req_i && !b_done) begin
          // A single-beat burst is finished in the same cycle it is granted.
          owner_d = StOwnB;
        end
      end
      StOwnA: begin
        if (!a_busy) owner_d = StIdle;
      end
      StOwnB: begin
        if (a_busy) begin
          owner_d = StOwnA;
        end else if (b_done) begin
          owner_d = StIdle;
        end
      end
      default: owner_d = StIdle;
    endcase
  end

  always_comb begin
    a_cnt_d      = a_cnt_q;
    frame_done_d = 1'b0;
    if (a_abort) begin
      a_cnt_d = '0;
    end else if (a_we_i) begin
      if (a_cnt_q == ALastCnt) begin
        a_cnt_d      = '0;
        frame_done_d = 1'b1;
      end else begin
        a_cnt_d = a_cnt_q + 1'b1;
      end
    end
  end

  // Write-port mux: A has absolute priority; address/data hold when idle.
  always_comb begin
    bram_we_d    = a_we_i | b_acc;
    bram_wad_d   = bram_wad_q;
    bram_wdata_d = bram_wdata_q;
    if (a_we_i) begin
      bram_wad_d   = a_wad_i;
      bram_wdata_d = a_wdata_i;
    end else if (b_acc) begin
      bram_wad_d   = b_wad_i;
      bram_wdata_d = b_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= StIdle;
      a_cnt_q      <= '0;
      a_session_q  <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_wad_q   <= '0;
      bram_wdata_q <= '0;
      frame_done_q <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      a_cnt_q      <= a_cnt_d;
      a_session_q  <= a_session_i;
      bram_we_q    <= bram_we_d;
      bram_wad_q   <= bram_wad_d;
      bram_wdata_q <= bram_wdata_d;
      frame_done_q <= frame_done_d;
      burst_done_q <= b_done;
    end
  end

  assign bram_we_o      = bram_we_q;
  assign bram_wad_o     = bram_wad_q;
  assign bram_wdata_o   = bram_wdata_q;
  assign a_frame_done_o = frame_done_q;
  assign b_burst_done_o = burst_done_q;
  assign owner_o        = owner_q;

endmodule

// File: tb/tb_bp_bram_write_arbiter.sv
// Scoreboard bench for bp_bram_write_arbiter: directed stimulus pushes the
// expected BRAM writes (with their due cycle), a negedge monitor pops them.
module tb_bp_bram_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_session, a_we, b_req, b_last;
  logic [5:0]  a_wad, b_wad;
  logic [95:0] a_wdata, b_wdata;
  logic        b_gnt, bram_we, a_frame_done, b_burst_done;
  logic [5:0]  bram_wad;
  logic [95:0] bram_wdata;
  logic [1:0]  owner;

  bp_bram_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_session_i    (a_session),
    .a_we_i         (a_we),
    .a_wad_i        (a_wad),
    .a_wdata_i      (a_wdata),
    .b_req_i        (b_req),
    .b_wad_i        (b_wad),
    .b_wdata_i      (b_wdata),
    .b_last_i       (b_last),
    .b_gnt_o        (b_gnt),
    .bram_we_o      (bram_we),
    .bram_wad_o     (bram_wad),
    .bram_wdata_o   (bram_wdata),
    .a_frame_done_o (a_frame_done),
    .b_burst_done_o (b_burst_done),
    .owner_o        (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  wad;
    logic [95:0] wdata;
    logic        fd;
    logic        bd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] bdata(input logic [5:0] w);
    return {32'hB0B0_0000, 58'd0, w};
  endfunction

  function automatic logic [95:0] adata(input logic [5:0] w);
    return {32'hA5A5_0000, 58'd0, w};
  endfunction

  task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] w, input logic [95:0] d, input logic fd, input logic bd);
    exp_t e;
    e.cyc = cyc + 1; e.wad = w; e.wdata = d; e.fd = fd; e.bd = bd;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    a_session = 0; a_we = 0; a_wad = '0; a_wdata = '0;
    b_req = 0; b_last = 0; b_wad = '0; b_wdata = '0;
  endtask

  task automatic a_beat(input logic sess, input logic [5:0] w, input logic [95:0] d);
    a_session = sess; a_we = 1; a_wad = w; a_wdata = d;
  endtask

  task automatic b_beat(input logic [5:0] w, input logic last);
    b_req = 1; b_wad = w; b_wdata = bdata(w); b_last = last;
  endtask

  // Check the combinational grant for this cycle, then advance one clock.
  task automatic tick(input logic exp_gnt, input string name);
    #1;
    check1(name, b_gnt, exp_gnt);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every BRAM write must match the next expected entry and its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_we) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: wad %0d data %0h at cycle %0d", bram_wad, bram_wdata,
                   cyc);
        end else begin
          mon_e = sb.pop_front();
          if (cyc != mon_e.cyc || bram_wad !== mon_e.wad || bram_wdata !== mon_e.wdata ||
              a_frame_done !== mon_e.fd || b_burst_done !== mon_e.bd) begin
            failures++;
            $display("FAIL bram_write: got cyc %0d wad %0d data %0h fd %b bd %b expected cyc %0d wad %0d data %0h fd %b bd %b",
                     cyc, bram_wad, bram_wdata, a_frame_done, b_burst_done, mon_e.cyc,
                     mon_e.wad, mon_e.wdata, mon_e.fd, mon_e.bd);
          end
        end
      end else begin
        if (a_frame_done || b_burst_done) begin
          checks++;
          failures++;
          $display("FAIL stray_pulse: fd %b bd %b without bram_we expected 0 0", a_frame_done,
                   b_burst_done);
        end
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_write: got none at cycle %0d expected wad %0d", cyc, sb[0].wad);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    // Reset state, with B requesting to confirm the grant is suppressed.
    b_beat(6'd1, 1'b0);
    #2;
    check1("rst_gnt", b_gnt, 0);
    check1("rst_we", bram_we, 0);
    check1("rst_owner", owner, 0);
    check1("rst_wad", bram_wad, 0);
    check1("rst_wdata", bram_wdata, 0);
    check1("rst_pulses", {a_frame_done, b_burst_done}, 0);
    idle_in();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // B burst alone: 40..47, last on beat 8.
    for (int i = 0; i < 8; i++) begin
      b_beat(6'(40 + i), i == 7);
      push(6'(40 + i), bdata(6'(40 + i)), 0, i == 7);
      tick(1, "gnt_b_alone");
    end
    idle_in();
    check1("owner_after_b", owner, 0);

    // Full A frame: wad/wdata 0..63, frame_done on the 64th.
    for (int i = 0; i < 64; i++) begin
      a_beat(1, 6'(i), 96'(i));
      push(6'(i), 96'(i), i == 63, 0);
      tick(0, "gnt_a_frame");
    end
    idle_in();
    tick(0, "gnt_a_release");
    check1("owner_after_a", owner, 0);

    // Preemption: A takes over after B beat 3 of 8; B resumes at 43.
    for (int i = 0; i < 3; i++) begin
      b_beat(6'(40 + i), 0);
      push(6'(40 + i), bdata(6'(40 + i)), 0, 0);
      tick(1, "gnt_pre_b");
    end
    b_beat(6'd43, 0);
    for (int j = 0; j < 4; j++) begin
      a_beat(1, 6'(10 + j), adata(6'(10 + j)));
      push(6'(10 + j), adata(6'(10 + j)), 0, 0);
      tick(0, "gnt_preempted");
    end
    check1("owner_preempt", owner, 1);
    a_session = 0; a_we = 0;
    tick(0, "gnt_a_leaving");
    for (int i = 3; i < 8; i++) begin
      b_beat(6'(40 + i), i == 7);
      push(6'(40 + i), bdata(6'(40 + i)), 0, i == 7);
      tick(1, "gnt_resume");
    end
    idle_in();
    check1("owner_after_pre", owner, 0);

    // Reset after B beat 5, then a full restart.
    for (int i = 0; i < 5; i++) begin
      b_beat(6'(40 + i), 0);
      push(6'(40 + i), bdata(6'(40 + i)), 0, 0);
      tick(1, "gnt_b_prerst");
    end
    b_beat(6'd45, 0);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    check1("midrst_we", bram_we, 0);
    check1("midrst_wad", bram_wad, 0);
    check1("midrst_wdata", bram_wdata, 0);
    check1("midrst_owner", owner, 0);
    check1("midrst_gnt", b_gnt, 0);
    idle_in();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      b_beat(6'(40 + i), i == 7);
      push(6'(40 + i), bdata(6'(40 + i)), 0, i == 7);
      tick(1, "gnt_restart");
    end
    idle_in();
    check1("owner_after_restart", owner, 0);

    // Aborted A frame of 20 beats, then a full frame pulses exactly once.
    for (int i = 0; i < 20; i++) begin
      a_beat(1, 6'(i), adata(6'(i)));
      push(6'(i), adata(6'(i)), 0, 0);
      tick(0, "gnt_abort_frame");
    end
    idle_in();
    tick(0, "gnt_abort_drop");
    for (int i = 0; i < 64; i++) begin
      a_beat(1, 6'(63 - i), 96'(i));
      push(6'(63 - i), 96'(i), i == 63, 0);
      tick(0, "gnt_frame2");
    end
    idle_in();
    tick(0, "gnt_frame2_drop");

    // Simultaneous A write and single-beat B burst in IDLE: A wins.
    a_we = 1; a_wad = 6'd7; a_wdata = adata(6'd7);
    b_beat(6'd50, 1);
    push(6'd7, adata(6'd7), 0, 0);
    tick(0, "gnt_simul");
    check1("owner_simul", owner, 1);
    a_we = 0;
    tick(0, "gnt_simul_owna");
    push(6'd50, bdata(6'd50), 0, 1);
    tick(1, "gnt_single_beat");
    idle_in();
    check1("owner_single_beat", owner, 0);

    // Idle: no write, address and data hold.
    tick(1, "gnt_idle");
    tick(1, "gnt_idle");
    check1("idle_we", bram_we, 0);
    check1("idle_wad_hold", bram_wad, 50);
    check1("idle_wdata_hold", bram_wdata, bdata(6'd50));

    repeat (4) @(posedge clk);
    #1;
    check1("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_bram_write_arbiter.md
BP_BRAM_WRITE_ARBITER -- requirements
Module: bp_bram_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning BRAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning BRAM address width.
REQ-003 The block SHALL have parameter FRAME_BEATS, default 64, meaning A-port words per complete decompressed polyvec.
REQ-004 clk  input  1  Single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  Reset; asynchronous, active-low.
REQ-006 a_session  input  1  Port A (ciphertext decompressor) session active; level.
REQ-007 a_we  input  1  Port A write strobe; not stallable.
REQ-008 a_wad  input  ADDR_W  Port A write address.
REQ-009 a_wdata  input  DATA_W  Port A write data.
REQ-010 b_req  input  1  Port B (polynomial arithmetic engine) write valid.
REQ-011 b_wad  input  ADDR_W  Port B write address.
REQ-012 b_wdata  input  DATA_W  Port B write data.
REQ-013 b_last  input  1  Final beat of the port B burst; qualified by b_req.
REQ-014 b_gnt  output  1  Port B beat accepted this cycle when b_req and b_gnt are both high.
REQ-015 bram_we  output  1  Shared BRAM write enable.
REQ-016 bram_wad  output  ADDR_W  Shared BRAM write address.
REQ-017 bram_wdata  output  DATA_W  Shared BRAM write data.
REQ-018 a_frame_done  output  1  One-cycle pulse after the FRAME_BEATS-th port A write.
REQ-019 b_burst_done  output  1  One-cycle pulse when the port B last beat is written.
REQ-020 owner  output  2  FSM state: 0 IDLE, 1 OWN_A, 2 OWN_B.

Function
REQ-021 The FSM SHALL have states IDLE, OWN_A and OWN_B.
REQ-022 IDLE SHALL go to OWN_A if a_session or a_we is high, else to OWN_B if b_req is high, else stay in IDLE.
REQ-023 OWN_A SHALL go to IDLE when a_session and a_we are both low, else stay in OWN_A.
REQ-024 OWN_B SHALL go to OWN_A when a_session or a_we is high (preemption), to IDLE on an accepted b_last, else stay in OWN_B.
REQ-025 b_gnt SHALL be combinational: high only when owner is not OWN_A, a_we is low and a_session is low.
REQ-026 Port A SHALL win every cycle: an a_we beat is written even when it arrives during an OWN_B burst, and B is stalled that cycle.
REQ-027 A preempted B burst SHALL resume in OWN_B with no lost or duplicated beat; B must hold its request stable while b_gnt is low.
REQ-028 The BRAM outputs SHALL be registered with latency 1: the accepted beat's address and data appear with bram_we one cycle later.
REQ-029 When no beat is accepted, bram_we SHALL be 0 and bram_wad and bram_wdata SHALL hold their last values.
REQ-030 A 7-bit A-beat counter SHALL increment on each a_we and wrap to 0 on reaching FRAME_BEATS.
REQ-031 a_frame_done SHALL pulse aligned with the bram_we of the FRAME_BEATS-th A beat.
REQ-032 b_burst_done SHALL pulse aligned with the bram_we of the accepted b_last beat.
REQ-033 The A counter SHALL clear when a_session falls while the count is nonzero, with no a_frame_done pulse.
REQ-034 Addresses SHALL pass through unchecked, with natural ADDR_W wrap; 0..63 are all legal.
REQ-035 A burst with b_last on its first beat SHALL be legal and SHALL return to IDLE after 1 beat.

Reset
REQ-036 On rst_n low, owner SHALL go to IDLE and bram_we, bram_wad, bram_wdata, a_frame_done, b_burst_done and the A counter SHALL go to 0 immediately.
REQ-037 Reset mid-burst SHALL abandon the burst; B must restart its burst after reset.
REQ-038 b_gnt SHALL be 0 during reset.

Structure
REQ-039 DATA_W, ADDR_W, FRAME_BEATS and the owner state encoding SHALL live in the shared Kyber package.
REQ-040 The implementation SHALL be one module with no sub-modules; the write-port mux and register are inline.

Verification
REQ-041 Full A frame: a_session=1, 64 a_we beats with wad 0..63 and wdata=wad -> 64 BRAM writes at +1 cycle, a_frame_done at the 64th, b_gnt=0 throughout.
REQ-042 B burst alone: 8 beats wad 40..47, b_last on beat 8 -> 8 writes, b_burst_done once, owner back to 0.
REQ-043 Preemption: A asserts a_session plus 4 a_we beats after B beat 3 of 8 -> B stalls, A's 4 writes occur, then B resumes at wad 43, total 12 writes with none duplicated.
REQ-044 Simultaneous request: a_we=1 and b_req=1 in IDLE -> A written, b_gnt=0, owner=1.
REQ-045 Reset mid-burst: rst_n low after B beat 5 -> outputs 0 immediately; B restart of 8 beats completes normally.
REQ-046 Aborted A frame: a_session falls after 20 beats -> no a_frame_done; next full 64-beat frame pulses a_frame_done exactly once.
